// File: rtl/systolic_ctrl_if.sv
// Bundles the signals of the 3x3 systolic array controller: the weight and input
// streams, the aligned output stream, and the wires to and from the array itself.
// The slave modport belongs to the controller. The master modport is the view
// from the host, which also stands in for the array.
interface systolic_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  // Weight set stream
  logic                  w_valid;
  logic                  w_ready;
  logic [9*DATA_W-1:0]   w_data;
  // Input vector stream
  logic                  in_valid;
  logic                  in_ready;
  logic [3*DATA_W-1:0]   in_data;
  logic                  in_last;
  // Array side
  logic [9*DATA_W-1:0]   arr_weight;
  logic                  arr_load;
  logic                  arr_start;
  logic [3*DATA_W-1:0]   arr_in;
  logic [3*DATA_W-1:0]   arr_out;
  // Aligned output stream and status
  logic                  out_valid;
  logic [3*DATA_W-1:0]   out_data;
  logic                  out_last;
  logic                  done;
  logic                  busy;

  modport master (
    output w_valid, w_data, in_valid, in_data, in_last, arr_out,
    input  w_ready, in_ready, arr_weight, arr_load, arr_start, arr_in,
    input  out_valid, out_data, out_last, done, busy
  );

  modport slave (
    input  w_valid, w_data, in_valid, in_data, in_last, arr_out,
    output w_ready, in_ready, arr_weight, arr_load, arr_start, arr_in,
    output out_valid, out_data, out_last, done, busy
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for a 3x3 weight-stationary systolic array. It latches a weight set and
// pulses load, then skews accepted input vectors diagonally into the array. It
// deskews the column outputs into aligned vectors with a fixed 7-cycle latency and
// pulses done on the last beat.
// Optional feature: define SYS_CTRL_PERF_EN to add the perf_cycles busy-cycle counter.
module systolic_ctrl #(
  parameter int unsigned DATA_W = 16
`ifdef SYS_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_ctrl_if.slave       bus
`ifdef SYS_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

  state_e state_q, state_d;
  logic   w_ready_q, w_ready_d;
  logic   in_ready_q, in_ready_d;
  logic   arr_load_q, arr_load_d;
  logic   arr_start_q, arr_start_d;
  logic   busy_q, busy_d;
  logic [9*DATA_W-1:0] weight_q, weight_d;

  // Skew registers: column i of the input vector passes through i stages.
  logic [DATA_W-1:0]        x1_q, x1_d;
  logic [1:0][DATA_W-1:0]   x2_q, x2_d;
  logic [2:0][DATA_W-1:0]   x3_q, x3_d;
  // Deskew registers: column 1 waits 2 extra cycles, column 2 waits 1.
  logic [1:0][DATA_W-1:0]   c1_q, c1_d;
  logic [DATA_W-1:0]        c2_q, c2_d;
  logic [3*DATA_W-1:0]      out_data_q, out_data_d;
  // Per-beat valid/last tags that travel alongside the data.
  logic [6:0]               vld_q, vld_d;
  logic [6:0]               last_q, last_d;

  logic                     w_fire;
  logic                     in_fire;
  logic [3*DATA_W-1:0]      x_in;

  assign w_fire  = bus.w_valid & w_ready_q;
  assign in_fire = bus.in_valid & in_ready_q;

  // Next state, and the state-decoded outputs registered alongside it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (w_fire) state_d = StLoad;
      StLoad:   state_d = StStream;
      StStream: if (in_fire && bus.in_last) state_d = StDrain;
      StDrain:  if (last_q[6]) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    w_ready_d   = (state_d == StIdle);
    in_ready_d  = (state_d == StStream);
    arr_load_d  = (state_d == StLoad);
    arr_start_d = (state_d == StStream) || (state_d == StDrain);
    busy_d      = (state_d != StIdle);
    weight_d    = w_fire ? bus.w_data : weight_q;
  end

  // FSM state, registered control outputs and the weight latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      w_ready_q   <= 1'b1;
      in_ready_q  <= 1'b0;
      arr_load_q  <= 1'b0;
      arr_start_q <= 1'b0;
      busy_q      <= 1'b0;
      weight_q    <= '0;
    end else begin
      state_q     <= state_d;
      w_ready_q   <= w_ready_d;
      in_ready_q  <= in_ready_d;
      arr_load_q  <= arr_load_d;
      arr_start_q <= arr_start_d;
      busy_q      <= busy_d;
      weight_q    <= weight_d;
    end
  end

  // Skew, deskew and tag pipelines; cycles without an accept inject a zero bubble.
  always_comb begin
    x_in       = in_fire ? bus.in_data : '0;
    x1_d       = x_in[0 +: DATA_W];
    x2_d       = {x2_q[0], x_in[DATA_W +: DATA_W]};
    x3_d       = {x3_q[1:0], x_in[2*DATA_W +: DATA_W]};
    c1_d       = {c1_q[0], bus.arr_out[0 +: DATA_W]};
    c2_d       = bus.arr_out[DATA_W +: DATA_W];
    out_data_d = {bus.arr_out[2*DATA_W +: DATA_W], c2_q, c1_q[1]};
    vld_d      = {vld_q[5:0], in_fire};
    last_d     = {last_q[5:0], in_fire & bus.in_last};
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q       <= '0;
      x2_q       <= '0;
      x3_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      out_data_q <= '0;
      vld_q      <= '0;
      last_q     <= '0;
    end else begin
      x1_q       <= x1_d;
      x2_q       <= x2_d;
      x3_q       <= x3_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      out_data_q <= out_data_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
    end
  end

  assign bus.w_ready    = w_ready_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.arr_weight = weight_q;
  assign bus.arr_load   = arr_load_q;
  assign bus.arr_start  = arr_start_q;
  assign bus.arr_in     = {x3_q[2], x2_q[1], x1_q};
  assign bus.out_valid  = vld_q[6];
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = last_q[6];
  assign bus.done       = last_q[6];
  assign bus.busy       = busy_q;

`ifdef SYS_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_q, perf_d;

  // Busy-cycle counter. It clears when a job is accepted and saturates at all-ones.
  always_comb begin
    perf_d = perf_q;
    if (w_fire) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
